// File: rtl/fp_addsub_seq_if.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq_if
//   Bundles the FP command handshake, the result handshake and the shared
//   significand-ALU connection of fp_addsub_seq.
//
//   Command : in_valid, in_ready, op_a, op_b, op_sub
//   ALU     : alu_a, alu_b, alu_sign_a, alu_sign_b, alu_symbol (to ALU)
//             alu_out (bit MAN_W+1 = carry), alu_sign_out     (from ALU)
//   Result  : out_valid, out_ready, result
//
//   slave  : the sequencer side.
//   master : the environment side (command source, ALU, result consumer).
// ---------------------------------------------------------------------------
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_sub;

  logic [MAN_W:0]   alu_a;
  logic [MAN_W:0]   alu_b;
  logic             alu_sign_a;
  logic             alu_sign_b;
  logic             alu_symbol;
  logic [MAN_W+1:0] alu_out;
  logic             alu_sign_out;

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;

  modport slave (
    input  in_valid, op_a, op_b, op_sub, alu_out, alu_sign_out, out_ready,
    output in_ready, alu_a, alu_b, alu_sign_a, alu_sign_b, alu_symbol,
           out_valid, result
  );

  modport master (
    output in_valid, op_a, op_b, op_sub, alu_out, alu_sign_out, out_ready,
    input  in_ready, alu_a, alu_b, alu_sign_a, alu_sign_b, alu_symbol,
           out_valid, result
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq
//   Multi-cycle IEEE-754 single-precision add/subtract sequencer. Unpacks the
//   operands, aligns the smaller-exponent significand one bit per cycle,
//   drives the external combinational sign-magnitude significand ALU for one
//   cycle, normalises one bit per cycle and repacks with truncation.
//   Denormal inputs are flushed to zero; NaN/Inf are resolved at accept.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, abandons any operation
//   bus   : fp_addsub_seq_if.slave (command, ALU and result signals)
// ---------------------------------------------------------------------------
module fp_addsub_seq #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int MAX_ALIGN = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_addsub_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int D_W   = $clog2(MAX_ALIGN + 1);

  localparam logic [EXP_W:0]   EXP_ALL = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   EXP_ONE = (EXP_W+1)'(1);
  localparam logic [D_W-1:0]   D_SAT   = D_W'(MAX_ALIGN);
  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t state_q, state_d;

  // Operand / working registers
  logic             sign_a_q, sign_b_q, sub_q;
  logic [SIG_W-1:0] sig_a_q, sig_b_q;
  logic [EXP_W:0]   exp_q;
  logic             shift_b_q;         // 1: B has the smaller exponent
  logic [D_W-1:0]   d_q;
  logic             special_q;         // result fully decided, bypass pack
  logic [W-1:0]     special_word_q;
  logic [SIG_W:0]   res_sig_q;
  logic             res_sign_q;

  // ALU drive registers, only loaded on the way into ADD
  logic [SIG_W-1:0] alu_a_q, alu_b_q;
  logic             alu_sign_a_q, alu_sign_b_q, alu_symbol_q;

  logic             out_valid_q;
  logic [W-1:0]     result_q;

  // Operand decode at accept
  logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             sign_a, sign_b;
  logic             nan_a, nan_b, inf_a, inf_b, a_ge;
  logic [D_W-1:0]   d_in;
  logic             special_in;
  logic [W-1:0]     special_word_in;
  logic [EXP_W:0]   exp_inc;
  logic             norm_done;

  assign sign_a = bus.op_a[W-1];
  assign sign_b = bus.op_b[W-1];
  assign exp_a  = bus.op_a[W-2 -: EXP_W];
  assign exp_b  = bus.op_b[W-2 -: EXP_W];
  assign frac_a = bus.op_a[MAN_W-1:0];
  assign frac_b = bus.op_b[MAN_W-1:0];

  assign nan_a = (exp_a == EXP_ALL[EXP_W-1:0]) && (frac_a != '0);
  assign nan_b = (exp_b == EXP_ALL[EXP_W-1:0]) && (frac_b != '0);
  assign inf_a = (exp_a == EXP_ALL[EXP_W-1:0]) && (frac_a == '0);
  assign inf_b = (exp_b == EXP_ALL[EXP_W-1:0]) && (frac_b == '0);

  assign a_ge     = (exp_a >= exp_b);
  assign exp_diff = a_ge ? (exp_a - exp_b) : (exp_b - exp_a);
  assign d_in     = (exp_diff >= EXP_W'(MAX_ALIGN)) ? D_SAT : exp_diff[D_W-1:0];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    special_in      = 1'b0;
    special_word_in = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a ^ sign_b ^ bus.op_sub))) begin
      special_in      = 1'b1;
      special_word_in = QNAN;
    end else if (inf_a) begin
      special_in      = 1'b1;
      special_word_in = {sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      // B enters the operation negated when subtracting
      special_in      = 1'b1;
      special_word_in = {sign_b ^ bus.op_sub, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  assign exp_inc   = exp_q + 1'b1;
  // NORM stops on carry, zero, normalised, or when one more left shift
  // would take the exponent to zero (flush).
  assign norm_done = res_sig_q[SIG_W] || (res_sig_q == '0) ||
                     res_sig_q[SIG_W-1] || (exp_q <= EXP_ONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ALIGN;
      ALIGN:   if (special_q) state_d = DONE;
               else if (d_q == '0) state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    if (norm_done) state_d = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      sub_q          <= 1'b0;
      sig_a_q        <= '0;
      sig_b_q        <= '0;
      exp_q          <= '0;
      shift_b_q      <= 1'b0;
      d_q            <= '0;
      special_q      <= 1'b0;
      special_word_q <= '0;
      res_sig_q      <= '0;
      res_sign_q     <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_sign_a_q   <= 1'b0;
      alu_sign_b_q   <= 1'b0;
      alu_symbol_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      result_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          sign_a_q       <= sign_a;
          sign_b_q       <= sign_b;
          sub_q          <= bus.op_sub;
          // Zero exponent flushes the operand (no hidden bit, no fraction)
          sig_a_q        <= (exp_a != '0) ? {1'b1, frac_a} : '0;
          sig_b_q        <= (exp_b != '0) ? {1'b1, frac_b} : '0;
          exp_q          <= {1'b0, a_ge ? exp_a : exp_b};
          shift_b_q      <= a_ge;
          d_q            <= d_in;
          special_q      <= special_in;
          special_word_q <= special_word_in;
        end
        ALIGN: if (!special_q) begin
          if (d_q == '0) begin
            alu_a_q      <= sig_a_q;
            alu_b_q      <= sig_b_q;
            alu_sign_a_q <= sign_a_q;
            alu_sign_b_q <= sign_b_q;
            alu_symbol_q <= sub_q;
          end else if (d_q == D_SAT) begin
            // Shift cap reached: everything would be shifted out anyway
            if (shift_b_q) sig_b_q <= '0;
            else           sig_a_q <= '0;
            d_q <= '0;
          end else begin
            if (shift_b_q) sig_b_q <= sig_b_q >> 1;
            else           sig_a_q <= sig_a_q >> 1;
            d_q <= d_q - 1'b1;
          end
        end
        ADD: begin
          res_sig_q  <= bus.alu_out;
          res_sign_q <= bus.alu_sign_out;
        end
        NORM: begin
          if (res_sig_q[SIG_W]) begin
            res_sig_q <= res_sig_q >> 1;
            exp_q     <= exp_inc;
            if (exp_inc >= EXP_ALL) begin
              special_q      <= 1'b1;
              special_word_q <= {res_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
          end else if (res_sig_q == '0) begin
            special_q      <= 1'b1;
            special_word_q <= '0;
          end else if (res_sig_q[SIG_W-1]) begin
            // already normalised
          end else if (exp_q <= EXP_ONE) begin
            special_q      <= 1'b1;
            special_word_q <= {res_sign_q, {(W-1){1'b0}}};
          end else begin
            res_sig_q <= res_sig_q << 1;
            exp_q     <= exp_q - 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle packs the result; it then holds until taken
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= special_q ? special_word_q
                           : {res_sign_q, exp_q[EXP_W-1:0], res_sig_q[MAN_W-1:0]};
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sign_a = alu_sign_a_q;
  assign bus.alu_sign_b = alu_sign_b_q;
  assign bus.alu_symbol = alu_symbol_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_seq
//   Directed bench for fp_addsub_seq. The bench plays the command source,
//   the result consumer and the external sign-magnitude significand ALU.
//   Latency is counted in rising edges from the accept edge to the edge
//   after which out_valid is seen high.
// ---------------------------------------------------------------------------
module tb_fp_addsub_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    int          lat;
  } vec_t;

  fp_addsub_seq_if bus ();

  fp_addsub_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // External ALU: (-1)^sa*a + (-1)^(sb^symbol)*b in sign-magnitude
  logic alu_sb_eff;
  assign alu_sb_eff = bus.alu_sign_b ^ bus.alu_symbol;

  always_comb begin
    bus.alu_out      = '0;
    bus.alu_sign_out = 1'b0;
    if (bus.alu_sign_a == alu_sb_eff) begin
      bus.alu_out      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      bus.alu_sign_out = bus.alu_sign_a;
    end else if (bus.alu_a >= bus.alu_b) begin
      bus.alu_out      = {1'b0, bus.alu_a - bus.alu_b};
      bus.alu_sign_out = bus.alu_sign_a;
    end else begin
      bus.alu_out      = {1'b0, bus.alu_b - bus.alu_a};
      bus.alu_sign_out = alu_sb_eff;
    end
  end

  // Present one command for exactly one edge; called at posedge+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat = -1 on timeout.
  task automatic wait_valid(output int lat, output bit ready_seen);
    bit seen;
    lat        = 0;
    ready_seen = 1'b0;
    seen       = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) seen = 1'b1;
      else if (bus.in_ready) ready_seen = 1'b1;
    end
    if (!seen) lat = -1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    total++;
    if (bus.result !== 32'h0) begin
      bad++; $display("FAIL reset_result got=%h want=00000000", bus.result);
    end
    total++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sign_a, bus.alu_sign_b, bus.alu_symbol} !== 51'd0) begin
      bad++; $display("FAIL reset_alu got=%h/%h/%b%b%b want=0", bus.alu_a, bus.alu_b,
                      bus.alu_sign_a, bus.alu_sign_b, bus.alu_symbol);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got in_ready=%b out_valid=%b want=1/0",
                      bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_arith();
    vec_t v [7];
    int   lat;
    bit   rdy;
    v[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4};  // 1+1, carry
    v[1] = '{32'h40400000, 32'h3F000000, 1'b1, 32'h40200000, 6};  // 3-0.5, d=2
    v[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4};  // exact cancel
    // d=1 drops B's LSB, so the difference is 2^-23 after 23 left shifts
    v[3] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 28};
    v[4] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 6};  // 1-2 = -1, n=1
    v[5] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4};  // overflow
    v[6] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 5};  // denormal flushed
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].sub);
      wait_valid(lat, rdy);
      total++;
      if (bus.result !== v[i].res) begin
        bad++; $display("FAIL arith[%0d]_result got=%h want=%h", i, bus.result, v[i].res);
      end
      total++;
      if (lat != v[i].lat) begin
        bad++; $display("FAIL arith[%0d]_latency got=%0d want=%0d", i, lat, v[i].lat);
      end
      total++;
      if (rdy) begin
        bad++; $display("FAIL arith[%0d]_in_ready got=1 during op want=0", i);
      end
      consume();
    end
  endtask

  task automatic test_specials();
    vec_t v [6];
    int   lat;
    bit   rdy;
    v[0] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 2};  // NaN + x
    v[1] = '{32'h3F800000, 32'h7F800001, 1'b1, 32'h7FC00000, 2};  // x - sNaN
    v[2] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2};  // Inf - Inf
    v[3] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2};  // Inf + -Inf
    v[4] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2};  // x - Inf
    v[5] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2};  // -Inf + x
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].sub);
      wait_valid(lat, rdy);
      total++;
      if (bus.result !== v[i].res) begin
        bad++; $display("FAIL special[%0d]_result got=%h want=%h", i, bus.result, v[i].res);
      end
      total++;
      if (lat != v[i].lat) begin
        bad++; $display("FAIL special[%0d]_latency got=%0d want=%0d", i, lat, v[i].lat);
      end
      consume();
    end
  endtask

  task automatic test_wide_align();
    vec_t v [3];
    int   lat;
    bit   rdy;
    v[0] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 28};  // d=24, 1.0 lost
    v[1] = '{32'h4F000000, 32'h3F800000, 1'b0, 32'h4F000000, 5};   // d=30, saturated
    v[2] = '{32'h3F800000, 32'h4F000000, 1'b1, 32'hCF000000, 5};   // A smaller, saturated
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].sub);
      wait_valid(lat, rdy);
      total++;
      if (bus.result !== v[i].res) begin
        bad++; $display("FAIL align[%0d]_result got=%h want=%h", i, bus.result, v[i].res);
      end
      total++;
      if (lat != v[i].lat) begin
        bad++; $display("FAIL align[%0d]_latency got=%0d want=%0d", i, lat, v[i].lat);
      end
      consume();
    end
  endtask

  task automatic test_alu_hold();
    int lat;
    bit rdy;
    issue(32'h40400000, 32'h3F000000, 1'b1);  // 3.0 - 0.5
    wait_valid(lat, rdy);
    total++;
    if (bus.alu_a !== 24'hC00000 || bus.alu_b !== 24'h200000) begin
      bad++; $display("FAIL alu_operands got=%h/%h want=c00000/200000", bus.alu_a, bus.alu_b);
    end
    total++;
    if ({bus.alu_sign_a, bus.alu_sign_b, bus.alu_symbol} !== 3'b001) begin
      bad++; $display("FAIL alu_ctrl got=%b%b%b want=001", bus.alu_sign_a, bus.alu_sign_b,
                      bus.alu_symbol);
    end
    consume();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.alu_a !== 24'hC00000 || bus.alu_symbol !== 1'b1) begin
      bad++; $display("FAIL alu_hold_idle got=%h/%b want=c00000/1", bus.alu_a, bus.alu_symbol);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit rdy;
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    wait_valid(lat, rdy);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h40000000 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL backpressure[%0d] got valid=%b result=%h in_ready=%b want=1/40000000/0",
                        i, bus.out_valid, bus.result, bus.in_ready);
      end
    end
    consume();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL after_handshake got valid=%b in_ready=%b want=0/1",
                      bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit rdy;
    issue(32'h4B800000, 32'h3F800000, 1'b0);  // long ALIGN
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got valid=%b in_ready=%b want=0/1",
                      bus.out_valid, bus.in_ready);
    end
    total++;
    if (bus.result !== 32'h0) begin
      bad++; $display("FAIL mid_reset_result got=%h want=00000000", bus.result);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    wait_valid(lat, rdy);
    total++;
    if (bus.result !== 32'h40000000 || lat != 4) begin
      bad++; $display("FAIL post_reset_op got result=%h lat=%0d want=40000000/4", bus.result, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_specials();
    test_wide_align();
    test_alu_hold();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
